// File: rtl/instr_sequencer.sv
// Fetch/decode/execute control FSM: fetches 1- and 2-byte instructions and emits one-cycle control strobes.
// Latency: 3 cycles per one-byte instruction, 5 per two-byte; strobes are high only in the EXEC cycle.
// Backpressure: run=0 stalls only in FETCH, and an instruction already past FETCH runs to completion.
module instr_sequencer #(
  parameter int         ADDR_W = 8,
  parameter logic [3:0] HLT_OP = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [7:0]        mem_data,
  input  logic              carry,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        ir,
  output logic [7:0]        imm,
  output logic              jump,
  output logic              jumpC,
  output logic              sin,
  output logic              InA,
  output logic              twone,
  output logic [2:0]        ula_op,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_FETCH_OP = 3'd2,
    S_LOAD_OP  = 3'd3,
    S_EXEC     = 3'd4,
    S_HALT     = 3'd5
  } state_t;

  // Opcodes that carry meaning for the sequencer itself.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_INA = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JC  = 4'h9;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [7:0]        ir_q;
  logic [7:0]        imm_q;
  logic              jump_q;
  logic              jumpC_q;
  logic              sin_q;
  logic              InA_q;
  logic              twone_q;
  logic [2:0]        ula_op_q;
  logic              halted_q;
  logic              illegal_q;

  // Decoder outputs for the opcode about to enter EXEC.
  logic [3:0] dec_op;
  logic       dec_two;
  logic       dec_jump;
  logic       dec_jumpC;
  logic       dec_sin;
  logic       dec_InA;
  logic       dec_twone;
  logic [2:0] dec_ula;
  logic       dec_ill;
  logic [3:0] exec_op;

  // Incremented PC used by both fetch states; wraps naturally at the top of the address space.
  assign pc_d    = pc_q + ADDR_W'(1);
  assign exec_op = ir_q[7:4];

  // In DECODE the opcode is still on the memory bus; in LOAD_OP it already sits in ir.
  assign dec_op = (state_q == S_DECODE) ? mem_data[7:4] : ir_q[7:4];

  // Opcode decode into strobe pattern and operand length.
  always_comb begin
    dec_two   = 1'b0;
    dec_jump  = 1'b0;
    dec_jumpC = 1'b0;
    dec_sin   = 1'b0;
    dec_InA   = 1'b0;
    dec_twone = 1'b0;
    dec_ula   = 3'd0;
    dec_ill   = 1'b0;
    if (dec_op != HLT_OP) begin
      case (dec_op)
        OP_NOP: ;
        OP_LDI: begin dec_two = 1'b1; dec_sin = 1'b1; end
        OP_ADD: begin dec_twone = 1'b1; dec_ula = 3'd1; end
        OP_SUB: begin dec_twone = 1'b1; dec_ula = 3'd2; end
        OP_AND: begin dec_twone = 1'b1; dec_ula = 3'd3; end
        OP_OR:  begin dec_twone = 1'b1; dec_ula = 3'd4; end
        OP_NOT: begin dec_sin = 1'b1; dec_ula = 3'd5; end
        OP_INA: begin dec_twone = 1'b1; dec_InA = 1'b1; end
        OP_JMP: begin dec_two = 1'b1; dec_jump = 1'b1; end
        OP_JC:  begin dec_two = 1'b1; dec_jumpC = 1'b1; end
        default: dec_ill = 1'b1;
      endcase
    end
  end

  // Sequencer FSM with registered strobes; strobes are loaded on the edge that enters EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      ir_q      <= 8'h00;
      imm_q     <= 8'h00;
      jump_q    <= 1'b0;
      jumpC_q   <= 1'b0;
      sin_q     <= 1'b0;
      InA_q     <= 1'b0;
      twone_q   <= 1'b0;
      ula_op_q  <= 3'd0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      jump_q    <= 1'b0;
      jumpC_q   <= 1'b0;
      sin_q     <= 1'b0;
      InA_q     <= 1'b0;
      twone_q   <= 1'b0;
      ula_op_q  <= 3'd0;
      illegal_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (run) begin
            pc_q    <= pc_d;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          ir_q <= mem_data;
          if (dec_two) begin
            state_q <= S_FETCH_OP;
          end else begin
            twone_q   <= dec_twone;
            sin_q     <= dec_sin;
            InA_q     <= dec_InA;
            ula_op_q  <= dec_ula;
            illegal_q <= dec_ill;
            state_q   <= S_EXEC;
          end
        end
        S_FETCH_OP: begin
          pc_q    <= pc_d;
          state_q <= S_LOAD_OP;
        end
        S_LOAD_OP: begin
          imm_q   <= mem_data;
          jump_q  <= dec_jump;
          jumpC_q <= dec_jumpC;
          sin_q   <= dec_sin;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if ((exec_op == OP_JMP) || ((exec_op == OP_JC) && carry)) begin
            pc_q <= ADDR_W'(imm_q);
          end
          if (exec_op == HLT_OP) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            state_q  <= S_FETCH;
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  // The read request must be visible in the FETCH cycle itself so data arrives in DECODE;
  // it is held low while reset is asserted so no read escapes a reset cycle.
  assign mem_rd = rst_n & (((state_q == S_FETCH) & run) | (state_q == S_FETCH_OP));

  assign pc      = pc_q;
  assign ir      = ir_q;
  assign imm     = imm_q;
  assign jump    = jump_q;
  assign jumpC   = jumpC_q;
  assign sin     = sin_q;
  assign InA     = InA_q;
  assign twone   = twone_q;
  assign ula_op  = ula_op_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: instruction-level reference model, directed programs plus random programs.
// Latency: checks every cycle of every instruction against the expected fetch/decode/exec timeline.
// Backpressure: run=0 idle cycles are inserted before fetches; run is randomised inside instructions.
module tb_instr_sequencer;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [7:0] mem_data;
  logic       carry;
  logic       mem_rd;
  logic [7:0] pc;
  logic [7:0] ir;
  logic [7:0] imm;
  logic       jump;
  logic       jumpC;
  logic       sin;
  logic       InA;
  logic       twone;
  logic [2:0] ula_op;
  logic       halted;
  logic       illegal;

  instr_sequencer #(.ADDR_W(8), .HLT_OP(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mem_data(mem_data), .carry(carry),
    .mem_rd(mem_rd), .pc(pc), .ir(ir), .imm(imm), .jump(jump), .jumpC(jumpC),
    .sin(sin), .InA(InA), .twone(twone), .ula_op(ula_op), .halted(halted),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory: data appears one cycle after the read request.
  logic [7:0] mem [256];
  always @(posedge clk) if (mem_rd) mem_data <= mem[pc];

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] m_pc;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Observable control vector: {mem_rd, pc, jump, jumpC, sin, InA, twone, ula_op, illegal, halted}
  function automatic logic [31:0] obs();
    return {13'd0, mem_rd, pc, jump, jumpC, sin, InA, twone, ula_op, illegal, halted};
  endfunction

  function automatic logic [31:0] expv(input logic mr, input logic [7:0] p,
                                       input logic [8:0] st, input logic h);
    return {13'd0, mr, p, st, h};
  endfunction

  // Architectural strobe table: {jump, jumpC, sin, InA, twone, ula_op[2:0], illegal}
  function automatic logic [8:0] ref_strobes(input logic [3:0] op);
    case (op)
      4'h0: return 9'b0;
      4'h1: return {5'b00100, 3'd0, 1'b0};
      4'h2: return {5'b00001, 3'd1, 1'b0};
      4'h3: return {5'b00001, 3'd2, 1'b0};
      4'h4: return {5'b00001, 3'd3, 1'b0};
      4'h5: return {5'b00001, 3'd4, 1'b0};
      4'h6: return {5'b00100, 3'd5, 1'b0};
      4'h7: return {5'b00011, 3'd0, 1'b0};
      4'h8: return {5'b10000, 3'd0, 1'b0};
      4'h9: return {5'b01000, 3'd0, 1'b0};
      4'hF: return 9'b0;
      default: return {5'b00000, 3'd0, 1'b1};
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    run   = 1'($urandom_range(0, 1));
    step();
    step();
    chk("reset_outs", obs(), 32'd0);
    chk("reset_ir_imm", {16'd0, ir, imm}, 32'd0);
    rst_n = 1'b1;
    run   = 1'b0;
    m_pc  = 8'h00;
  endtask

  // Execute one instruction at the model PC, checking every cycle. cmode: 0/1 forced carry, 2 random.
  task automatic run_instr(input int idle, input int cmode);
    logic [7:0] p, b, o, p1, p2, pe;
    logic [3:0] op;
    logic       two, c;
    logic [8:0] st;
    p   = m_pc;
    b   = mem[p];
    op  = b[7:4];
    p1  = p + 8'd1;
    p2  = p + 8'd2;
    o   = mem[p1];
    two = (op == 4'h1) || (op == 4'h8) || (op == 4'h9);
    st  = ref_strobes(op);
    repeat (idle) begin
      run = 1'b0;
      #1;
      chk("idle_hold", obs(), expv(1'b0, p, 9'd0, 1'b0));
      step();
    end
    run = 1'b1;
    #1;
    chk("fetch", obs(), expv(1'b1, p, 9'd0, 1'b0));
    step();
    run = 1'($urandom_range(0, 1));
    #1;
    chk("decode", obs(), expv(1'b0, p1, 9'd0, 1'b0));
    step();
    if (two) begin
      chk("fetch_op", obs(), expv(1'b1, p1, 9'd0, 1'b0));
      chk("fetch_op_ir", {24'd0, ir}, {24'd0, b});
      step();
      chk("load_op", obs(), expv(1'b0, p2, 9'd0, 1'b0));
      step();
    end
    c     = (cmode == 2) ? 1'($urandom_range(0, 1)) : (cmode == 1);
    carry = c;
    #1;
    pe = two ? p2 : p1;
    chk("exec", obs(), expv(1'b0, pe, st, 1'b0));
    chk("exec_ir", {24'd0, ir}, {24'd0, b});
    if (two) chk("exec_imm", {24'd0, imm}, {24'd0, o});
    step();
    m_pc = pe;
    if ((op == 4'h8) || ((op == 4'h9) && c)) m_pc = o;
    if (op == 4'hF) begin
      repeat (20) begin
        run = 1'b1;
        #1;
        chk("halt_hold", obs(), expv(1'b0, pe, 9'd0, 1'b1));
        step();
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    carry = 1'b0;
    mem_data = 8'h00;
    clear_mem();

    // Two one-byte ALU ops back to back.
    mem[0] = 8'h20; mem[1] = 8'h30;
    do_reset();
    run_instr(0, 0);
    run_instr(0, 0);

    // LDI with operand.
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'h5A;
    do_reset();
    run_instr(0, 0);
    chk("ldi_pc", {24'd0, pc}, 32'h02);

    // JC at address 4, not taken then taken.
    for (int k = 0; k < 2; k++) begin
      clear_mem();
      mem[0] = 8'h10; mem[1] = 8'h11; mem[4] = 8'h90; mem[5] = 8'h20;
      do_reset();
      run_instr(0, 0);
      run_instr(1, 0);
      run_instr(0, 0);
      run_instr(0, k);
      chk("jc_pc", {24'd0, pc}, (k == 1) ? 32'h20 : 32'h06);
    end

    // JMP whose operand fetch wraps the PC.
    clear_mem();
    mem[0] = 8'h80; mem[1] = 8'hFE; mem[8'hFE] = 8'h80; mem[8'hFF] = 8'h03;
    do_reset();
    run_instr(0, 0);
    run_instr(0, 0);
    chk("jmp_wrap_pc", {24'd0, pc}, 32'h03);

    // NOP at the top of memory wraps the PC.
    clear_mem();
    mem[0] = 8'h80; mem[1] = 8'hFF; mem[8'hFF] = 8'h00;
    do_reset();
    run_instr(0, 0);
    run_instr(0, 0);
    chk("nop_wrap_pc", {24'd0, pc}, 32'h00);

    // Illegal opcode, then HLT with run held high.
    clear_mem();
    mem[0] = 8'hB0; mem[1] = 8'h00; mem[2] = 8'hF0;
    do_reset();
    run_instr(0, 0);
    run_instr(0, 0);
    run_instr(0, 0);
    do_reset();

    // Reset during the operand fetch of an LDI: the instruction is dropped.
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'h5A;
    do_reset();
    run = 1'b1;
    step();
    step();
    chk("mid_ldi_fetch_op", obs(), expv(1'b1, 8'h01, 9'd0, 1'b0));
    rst_n = 1'b0;
    step();
    chk("mid_ldi_reset_outs", obs(), 32'd0);
    chk("mid_ldi_reset_ir_imm", {16'd0, ir, imm}, 32'd0);
    step();
    chk("mid_ldi_no_sin", {31'd0, sin}, 32'd0);
    rst_n = 1'b1;
    run   = 1'b0;
    m_pc  = 8'h00;
    run_instr(5, 0);

    // Random programs without HLT, with random stalls and carry.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 256; i++) mem[i] = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
      do_reset();
      for (int n = 0; n < 150; n++) run_instr($urandom_range(0, 2), 2);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
